// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, combinational imem address, registered {pc, ir} slot to decode.
// Latency: one edge from PC to a valid slot; redirects cost one bubble.
// Backpressure: a full slot with out_ready low holds pc and the slot; redirect overrides the stall.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          ADDR_W   = 6
) (
    input  logic              clock,
    input  logic              reset_,
    output logic [ADDR_W-1:0] imem_address,
    input  logic [31:0]       imem_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_ir,
    output logic [31:0]       out_pc,
    output logic              halted,
    output logic              fault
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } slot_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    slot_t       slot_q, slot_d;
    logic        vld_q, vld_d;
    logic        halted_q, fault_q;

    logic slot_free;
    logic xfer;
    logic tgt_misaligned;

    assign slot_free      = !vld_q || out_ready;
    assign xfer           = vld_q && out_ready;
    assign tgt_misaligned = (redirect_pc[1:0] != 2'b00);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        slot_d  = slot_q;
        vld_d   = vld_q;

        case (state_q)
            ST_RUN: begin
                if (redirect) begin
                    // Flush: an instruction accepted this same edge is already consumed.
                    pc_d    = redirect_pc;
                    vld_d   = 1'b0;
                    state_d = tgt_misaligned ? ST_FAULT : ST_RUN;
                end else if (slot_free) begin
                    slot_d.pc = pc_q;
                    slot_d.ir = imem_data;
                    vld_d     = 1'b1;
                    pc_d      = pc_q + 32'd4;
                    if (imem_data == EBREAK) begin
                        state_d = ST_HALT;
                    end
                end
            end

            ST_HALT: begin
                if (redirect) begin
                    pc_d    = redirect_pc;
                    vld_d   = 1'b0;
                    state_d = tgt_misaligned ? ST_FAULT : ST_RUN;
                end else if (xfer) begin
                    vld_d = 1'b0;
                end
            end

            ST_FAULT: begin
                vld_d = 1'b0;
            end

            default: begin
                state_d = ST_FAULT;
                vld_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_PC;
            slot_q   <= '0;
            vld_q    <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            slot_q   <= slot_d;
            vld_q    <= vld_d;
            halted_q <= (state_d == ST_HALT);
            fault_q  <= (state_d == ST_FAULT);
        end
    end

    // Upper PC bits alias onto the 64-word memory.
    assign imem_address = pc_q[ADDR_W+1:2];
    assign out_valid    = vld_q;
    assign out_ir       = slot_q.ir;
    assign out_pc       = slot_q.pc;
    assign halted       = halted_q;
    assign fault        = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stream, stall, redirect, halt, fault and wrap cases.
module tb_fetch_unit;

    logic        clock = 1'b0;
    logic        reset_;
    logic [5:0]  imem_address, imem_address2;
    logic [31:0] imem_data, imem_data2;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid, out_valid2;
    logic        out_ready;
    logic [31:0] out_ir, out_ir2, out_pc, out_pc2;
    logic        halted, halted2, fault, fault2;
    logic        redirect2;
    logic [31:0] redirect_pc2;
    logic        out_ready2;

    logic [31:0] mem [64];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    assign imem_data  = mem[imem_address];
    assign imem_data2 = mem[imem_address2];

    fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_W(6)) dut (
        .clock(clock), .reset_(reset_),
        .imem_address(imem_address), .imem_data(imem_data),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_ir(out_ir), .out_pc(out_pc),
        .halted(halted), .fault(fault)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .ADDR_W(6)) dut_wrap (
        .clock(clock), .reset_(reset_),
        .imem_address(imem_address2), .imem_data(imem_data2),
        .redirect(redirect2), .redirect_pc(redirect_pc2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .out_ir(out_ir2), .out_pc(out_pc2),
        .halted(halted2), .fault(fault2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ir);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".pc"}, out_pc, pc);
        chk({tag, ".ir"}, out_ir, ir);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[5] = 32'h0010_0073;

        reset_ = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
        redirect2 = 1'b0; redirect_pc2 = 32'h0; out_ready2 = 1'b1;

        // Reset, with a misaligned redirect held that must be ignored
        step();
        redirect = 1'b1; redirect_pc = 32'h0000_0022;
        step();
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.ir", out_ir, 32'h0);
        chk("rst.pc", out_pc, 32'h0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.fault", {31'd0, fault}, 32'd0);
        chk("rst.addr", {26'd0, imem_address}, 32'd0);
        chk("rst.addr_wrapdut", {26'd0, imem_address2}, 32'd63);
        redirect = 1'b0; redirect_pc = 32'h0;
        reset_ = 1'b1;

        // Stream
        step();
        chk_slot("s0", 1'b1, 32'h0, 32'h1000_0000);
        chk("s0.wrap_pc", out_pc2, 32'hFFFF_FFFC);
        chk("s0.wrap_ir", out_ir2, 32'h1000_003F);
        step();
        chk_slot("s1", 1'b1, 32'h4, 32'h1000_0001);
        chk("s1.wrap_pc", out_pc2, 32'h0);
        chk("s1.wrap_ir", out_ir2, 32'h1000_0000);
        step();
        chk_slot("s2", 1'b1, 32'h8, 32'h1000_0002);
        chk("s2.addr", {26'd0, imem_address}, 32'd3);

        // Stall three cycles
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_slot("stall", 1'b1, 32'h8, 32'h1000_0002);
            chk("stall.addr", {26'd0, imem_address}, 32'd3);
        end
        out_ready = 1'b1;
        step();
        chk_slot("post_stall0", 1'b1, 32'hC, 32'h1000_0003);
        step();
        chk_slot("post_stall1", 1'b1, 32'h10, 32'h1000_0004);

        // Redirect while stalled
        out_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0040;
        step();
        redirect = 1'b0; out_ready = 1'b1;
        chk("rd_bubble.valid", {31'd0, out_valid}, 32'd0);
        chk("rd_bubble.addr", {26'd0, imem_address}, 32'd16);
        step();
        chk_slot("rd_target", 1'b1, 32'h40, 32'h1000_0010);

        // Redirect while the slot is being consumed
        redirect = 1'b1; redirect_pc = 32'h0000_0080;
        step();
        redirect = 1'b0;
        chk("rd2_bubble.valid", {31'd0, out_valid}, 32'd0);
        step();
        chk_slot("rd2_target", 1'b1, 32'h80, 32'h1000_0020);
        step();
        chk_slot("rd2_next", 1'b1, 32'h84, 32'h1000_0021);

        // Halt on EBREAK at word 5
        redirect = 1'b1; redirect_pc = 32'h0000_0010;
        step();
        redirect = 1'b0;
        step();
        chk_slot("pre_halt", 1'b1, 32'h10, 32'h1000_0004);
        chk("pre_halt.halted", {31'd0, halted}, 32'd0);
        step();
        chk_slot("ebreak", 1'b1, 32'h14, 32'h0010_0073);
        chk("ebreak.halted", {31'd0, halted}, 32'd1);
        out_ready = 1'b0;
        step();
        chk_slot("halt_hold", 1'b1, 32'h14, 32'h0010_0073);
        out_ready = 1'b1;
        step();
        chk("halt_drain.valid", {31'd0, out_valid}, 32'd0);
        chk("halt_drain.halted", {31'd0, halted}, 32'd1);
        step();
        chk("halt_idle.valid", {31'd0, out_valid}, 32'd0);

        // Resume from HALT
        redirect = 1'b1; redirect_pc = 32'h0;
        step();
        redirect = 1'b0;
        chk("resume.halted", {31'd0, halted}, 32'd0);
        chk("resume.valid", {31'd0, out_valid}, 32'd0);
        step();
        chk_slot("resume_first", 1'b1, 32'h0, 32'h1000_0000);

        // Misaligned redirect -> FAULT
        redirect = 1'b1; redirect_pc = 32'h0000_0022;
        step();
        chk("fault.fault", {31'd0, fault}, 32'd1);
        chk("fault.valid", {31'd0, out_valid}, 32'd0);
        redirect_pc = 32'h0000_0040;
        step();
        redirect = 1'b0;
        chk("fault_sticky.fault", {31'd0, fault}, 32'd1);
        chk("fault_sticky.valid", {31'd0, out_valid}, 32'd0);
        chk("fault_sticky.addr", {26'd0, imem_address}, 32'd8);
        step();
        chk("fault_hold.fault", {31'd0, fault}, 32'd1);
        reset_ = 1'b0;
        step();
        chk("fault_rst.fault", {31'd0, fault}, 32'd0);
        chk("fault_rst.addr", {26'd0, imem_address}, 32'd0);
        reset_ = 1'b1;

        // Wrap of the word address
        step();
        chk_slot("wrap_pre", 1'b1, 32'h0, 32'h1000_0000);
        redirect = 1'b1; redirect_pc = 32'h0000_00FC;
        step();
        redirect = 1'b0;
        chk("wrap.addr63", {26'd0, imem_address}, 32'd63);
        step();
        chk_slot("wrap_fc", 1'b1, 32'hFC, 32'h1000_003F);
        chk("wrap.addr0", {26'd0, imem_address}, 32'd0);
        step();
        chk_slot("wrap_100", 1'b1, 32'h100, 32'h1000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the RISC-V CPU, directly upstream of `instructionMemory`. Holds the program counter and drives the 6-bit word address into the combinational instruction memory. Captures the returned 32-bit word into an output register and hands `{pc, ir}` to decode over a valid/ready handshake. Supports branch/jump redirect with flush, back-pressure stall, halt on EBREAK and a sticky misaligned-target fault.

## Interface
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.
- `ADDR_W`, 6: instruction-memory word-address width (64 words).
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset_`  in  1  synchronous, active-low reset; sampled on the rising edge of `clock`.
- `imem_address`  out  ADDR_W  word address to instruction memory; `pc[ADDR_W+1:2]`, combinational from the PC register.
- `imem_data`  in  32  instruction word returned combinationally by memory for `imem_address`.
- `redirect`  in  1  taken branch/jump from execute; has priority over everything except reset.
- `redirect_pc`  in  32  byte target address, valid when `redirect`=1.
- `out_valid`  out  1  `out_ir`/`out_pc` hold an instruction for decode.
- `out_ready`  in  1  decode accepts; transfer occurs when `out_valid & out_ready` at a rising edge.
- `out_ir`  out  32  fetched instruction.
- `out_pc`  out  32  byte address of `out_ir`.
- `halted`  out  1  high in the HALT state.
- `fault`  out  1  high in the FAULT state (misaligned redirect target).

## Operation
- States: RUN, HALT, FAULT. Reset state is RUN.
- Slot-free condition: `!out_valid | out_ready`.
- The following rules apply in RUN, in priority order:
  1. If `redirect`=1 and `redirect_pc[1:0]`≠0: `pc<=redirect_pc`, `out_valid<=0`, state becomes FAULT.
  2. If `redirect`=1 and `redirect_pc` is aligned: `pc<=redirect_pc`, `out_valid<=0` (flush). No fetch occurs this cycle. If `out_valid & out_ready` held in the same cycle, the old instruction counts as transferred.
  3. If the slot is free: `out_ir<=imem_data`, `out_pc<=pc`, `out_valid<=1`, `pc<=pc+4`. If `imem_data`==32'h0010_0073 (EBREAK), state becomes HALT after the capture. The EBREAK itself is still delivered to decode.
  4. Otherwise (`out_valid & !out_ready`): stall. `pc`, `out_ir`, `out_pc` and `out_valid` hold.
- HALT state:
  - No fetch occurs.
  - The output slot drains normally: `out_valid<=0` on transfer.
  - An aligned `redirect` flushes the slot, loads `pc` and returns to RUN.
  - A misaligned `redirect` goes to FAULT.
- FAULT state:
  - Sticky until reset; no fetch and `out_valid`=0.
  - `redirect` is ignored.
  - `pc` keeps the faulting target.
- Arithmetic:
  - `pc+4` is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - PC bits above `ADDR_W+1` are ignored for addressing (alias), so address 63 is followed by 0.

## Timing
- Reset values (`reset_`=0 at an edge):
  - `pc`=`RESET_PC`, state RUN.
  - `out_valid`=0, `out_ir`=0, `out_pc`=0.
  - `halted`=0, `fault`=0.
  - `imem_address`=`RESET_PC[ADDR_W+1:2]`.
- Reset mid-operation (stall, HALT or FAULT) unconditionally returns to these values on that edge.
- Latency:
  - First instruction: `out_valid`=1 after the first rising edge with `reset_`=1, with `out_ir`=mem[`RESET_PC>>2`].
  - Throughput is one instruction per cycle while `out_ready`=1.
- Redirect penalty: one bubble. At the redirect edge `out_valid`=0. The target instruction appears on the next edge.
- `halted` and `fault` are registered, asserting on the edge that enters the state.
- All outputs except `imem_address` are registered; `imem_address` follows `pc` combinationally.
- `redirect` during reset is ignored.

## Test plan
- Reset/stream:
  - Stimulus: memory holds word *i* = 32'h1000_0000+i, `out_ready`=1, release reset.
  - Required response: consecutive edges give `out_pc`=0,4,8,… and `out_ir`=32'h1000_0000, …_0001, …_0002, with `out_valid` continuously 1.
- Stall:
  - Stimulus: drop `out_ready` for 3 cycles while `out_pc`=8.
  - Required response: `out_pc`=8, `out_ir`=32'h1000_0002 and `imem_address`=3 hold for 3 cycles. After release the next outputs are `out_pc`=12, then 16, with no loss or duplication.
- Redirect:
  - Stimulus: pulse `redirect` with `redirect_pc`=32'h0000_0040 while stalled.
  - Required response: `out_valid`=0 for one cycle, then `out_pc`=32'h40 and `out_ir`=mem[16].
  - Repeat with `out_ready`=1: the old instruction is consumed, then the same one bubble follows.
- Halt:
  - Stimulus: word 5 = 32'h0010_0073.
  - Required response: `out_ir`=32'h0010_0073 with `out_pc`=20 is delivered, `halted`=1 on the same edge, and no further valid after the transfer.
  - Then redirect to 0: `halted`=0 and fetch resumes at `out_pc`=0.
- Fault:
  - Stimulus: redirect to 32'h0000_0022.
  - Required response: `fault`=1 and `out_valid`=0 stay constant; a later aligned redirect has no effect; only `reset_`=0 clears the fault.
- Wrap:
  - Stimulus: redirect to 32'h0000_00FC.
  - Required response: `imem_address`=63, then 0, with `out_pc`=32'hFC followed by 32'h100.
  - Repeat from `RESET_PC`=32'hFFFF_FFFC: the next `out_pc` is 0.
